// File: rtl/scan_test_ctrl.sv
// rtl/scan_test_ctrl.sv - scan chain test sequencer: shift in, capture, shift out, compare
module scan_test_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 4,
  parameter int FCNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expect_in,
  input  logic                 scan_out,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] resp_out,
  output logic [FCNT_W-1:0]    fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  state_t               state, next_state;
  logic [CNT_W-1:0]     cnt, next_cnt;
  logic [CHAIN_LEN-1:0] pat_q, exp_q, resp_sh;
  logic [CHAIN_LEN-1:0] pat_src, pat_shifted;
  logic                 scan_en_d, scan_in_d, busy_d, done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Counter restarts at zero on every state change, so it never wraps inside a state.
  always_comb begin
    next_state = state;
    next_cnt   = '0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_SHIFT_IN;
      end
      S_SHIFT_IN: begin
        if (cnt == LAST) next_state = S_CAPTURE;
        else             next_cnt   = cnt + 1'b1;
      end
      S_CAPTURE: next_state = S_SHIFT_OUT;
      S_SHIFT_OUT: begin
        if (cnt == LAST) next_state = S_DONE;
        else             next_cnt   = cnt + 1'b1;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the upcoming state and count.
  always_comb begin
    pat_src     = (state == S_IDLE) ? pattern_in : pat_q;
    pat_shifted = pat_src >> (LAST - next_cnt);
    scan_en_d   = (next_state == S_SHIFT_IN) || (next_state == S_SHIFT_OUT);
    scan_in_d   = (next_state == S_SHIFT_IN) ? pat_shifted[0] : 1'b0;
    busy_d      = (next_state != S_IDLE);
    done_d      = (next_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_en  <= 1'b0;
      scan_in  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      resp_out <= '0;
      fail_cnt <= '0;
      pat_q    <= '0;
      exp_q    <= '0;
      resp_sh  <= '0;
    end else begin
      scan_en <= scan_en_d;
      scan_in <= scan_in_d;
      busy    <= busy_d;
      done    <= done_d;
      if (state == S_IDLE && start) begin
        pat_q <= pattern_in;
        exp_q <= expect_in;
      end
      // First sample is chain position CHAIN_LEN-1 and ends up in the MSB.
      if (state == S_SHIFT_OUT) resp_sh <= {resp_sh[CHAIN_LEN-2:0], scan_out};
      if (state == S_DONE) begin
        resp_out <= resp_sh;
        pass     <= (resp_sh == exp_q);
        if (resp_sh != exp_q && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      end
    end
  end

endmodule
